// File: rtl/apb_slave_regbank.sv
// APB3/APB4 completer: NUM_REGS byte-strobed 32-bit registers behind a fixed
// number of wait states, with PSLVERR on out-of-range word addresses.
module apb_slave_regbank #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic [ADDRWIDTH-1:0]          PADDR,
    input  logic                          PWRITE,
    input  logic [DATAWIDTH-1:0]          PWDATA,
    input  logic [3:0]                    PSTRB,
    input  logic [2:0]                    PPROT,
    output logic [DATAWIDTH-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NUM_REGS*DATAWIDTH-1:0] REG_OUT
);
    localparam int IDXW = ADDRWIDTH - 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]           strb_q, strb_d;
    logic [DATAWIDTH-1:0] prdata_q, prdata_d;
    logic [DATAWIDTH-1:0] regs_q [NUM_REGS];
    logic [DATAWIDTH-1:0] regs_d [NUM_REGS];

    logic [IDXW-1:0]      setup_idx;
    logic                 setup_err;
    logic [DATAWIDTH-1:0] setup_rdata;
    logic                 unused_pins;

    assign setup_idx   = PADDR[ADDRWIDTH-1:2];
    assign setup_err   = ({1'b0, setup_idx} >= (IDXW+1)'(NUM_REGS));
    assign unused_pins = ^{PPROT, PADDR[1:0]};

    // Read data is captured at the setup edge so PRDATA is stable for the whole access phase.
    always_comb begin
        setup_rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (setup_idx == IDXW'(k)) begin
                setup_rdata = regs_q[k];
            end
        end
    end

    assign PREADY  = (state_q == ST_ACCESS) && PSEL && PENABLE && (wcnt_q == 4'd0);
    assign PSLVERR = PREADY && err_q;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        regs_d   = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = setup_idx;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    err_d   = setup_err;
                    wcnt_d  = 4'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                    if (!PWRITE) begin
                        prdata_d = setup_err ? '0 : setup_rdata;
                    end
                end
            end
            default: begin
                // A dropped PSEL is a master abort: leave without committing anything.
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (PENABLE) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        if (write_q && !err_q) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (idx_q == IDXW'(k)) begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (strb_q[b]) begin
                                            regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                                        end
                                    end
                                end
                            end
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    assign PRDATA = prdata_q;

    always_comb begin
        REG_OUT = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            REG_OUT[k*DATAWIDTH +: DATAWIDTH] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: three register banks with 0, 2 and 3 wait states, each on
// its own APB bus, checked against an array-based model of the register file.
module tb_apb_slave_regbank;
    localparam int NINST = 3;
    localparam int NREGS = 16;

    logic        clock = 1'b0;
    logic        preset = 1'b1;
    logic        psel    [NINST];
    logic        penable [NINST];
    logic        pwrite  [NINST];
    logic [15:0] paddr   [NINST];
    logic [31:0] pwdata  [NINST];
    logic [3:0]  pstrb   [NINST];
    logic [2:0]  pprot   [NINST];
    logic [31:0] prdata  [NINST];
    logic        pready  [NINST];
    logic        pslverr [NINST];
    logic [511:0] reg_out [NINST];

    int wait_of [NINST] = '{0, 2, 3};

    logic [31:0] model_mem    [NINST][NREGS];
    logic [31:0] model_prdata [NINST];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    apb_slave_regbank #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) u_w0 (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
        .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .REG_OUT(reg_out[0]));

    apb_slave_regbank #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) u_w2 (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
        .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .REG_OUT(reg_out[1]));

    apb_slave_regbank #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3)) u_w3 (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]), .PADDR(paddr[2]),
        .PWRITE(pwrite[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]), .PPROT(pprot[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .REG_OUT(reg_out[2]));

    typedef struct {
        int          inst;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          b2b;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_flat(input int k);
        logic [511:0] v;
        v = '0;
        for (int r = 0; r < NREGS; r++) v[r*32 +: 32] = model_mem[k][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NINST; k++) begin
            model_prdata[k] = '0;
            for (int r = 0; r < NREGS; r++) model_mem[k][r] = '0;
        end
    endtask

    task automatic bus_idle(input int k);
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
        paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0; pprot[k] = '0;
    endtask

    // One full APB transfer, entered at a falling edge; the access phase scrambles
    // PADDR/PWDATA/PSTRB so only the values latched at setup may matter.
    task automatic applyStimulus(input int k, input bit wr, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb, input bit b2b,
                                 output logic [31:0] rdata, output logic err);
        int idx;
        bit is_err;
        int cycles;
        idx = int'(addr[15:2]);
        is_err = (idx >= NREGS);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = wdata; pstrb[k] = strb; pprot[k] = 3'($urandom);
        if (!wr) model_prdata[k] = is_err ? 32'h0 : model_mem[k][idx];
        @(negedge clock);
        penable[k] = 1'b1;
        paddr[k] = 16'($urandom); pwdata[k] = $urandom; pstrb[k] = 4'($urandom);
        cycles = 1;
        #1;
        while (!pready[k] && cycles < 40) begin
            @(negedge clock);
            cycles++;
            #1;
        end
        checkOutput($sformatf("latency_i%0d", k), 512'(cycles), 512'(wait_of[k] + 1));
        checkOutput($sformatf("pslverr_i%0d_a%0h", k, addr), 512'(pslverr[k]), 512'(is_err));
        checkOutput($sformatf("prdata_access_i%0d_a%0h", k, addr), 512'(prdata[k]), 512'(model_prdata[k]));
        rdata = prdata[k];
        err = pslverr[k];
        @(negedge clock);
        last_done_cyc = cyc;
        if (wr && !is_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        checkOutput($sformatf("reg_out_i%0d_a%0h", k, addr), reg_out[k], model_flat(k));
        checkOutput($sformatf("prdata_hold_i%0d", k), 512'(prdata[k]), 512'(model_prdata[k]));
        if (!b2b) begin
            bus_idle(k);
            @(negedge clock);
        end
    endtask

    vec_t vecs [$];

    initial begin
        logic [31:0] rd;
        logic er;
        int start;

        for (int k = 0; k < NINST; k++) bus_idle(k);
        model_reset();

        vecs.push_back('{0, 1, 16'h0008, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0});
        vecs.push_back('{0, 0, 16'h0008, 32'h0,        4'hF, 0, 32'hDEADBEEF, 0});
        vecs.push_back('{0, 1, 16'h0004, 32'h11223344, 4'hF, 0, 32'h0, 0});
        vecs.push_back('{0, 1, 16'h0004, 32'hAABBCCDD, 4'h5, 0, 32'h0, 0});
        vecs.push_back('{0, 0, 16'h0004, 32'h0,        4'hF, 0, 32'h11BB33DD, 0});
        vecs.push_back('{0, 1, 16'h0040, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1});
        vecs.push_back('{0, 0, 16'h0040, 32'h0,        4'hF, 0, 32'h0, 1});
        vecs.push_back('{0, 1, 16'h0000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 0});
        vecs.push_back('{0, 1, 16'h0000, 32'h00000000, 4'hF, 1, 32'h0, 0});
        vecs.push_back('{0, 0, 16'h0000, 32'h0,        4'hF, 0, 32'h0, 0});
        vecs.push_back('{1, 0, 16'h0004, 32'h0,        4'hF, 0, 32'h0, 0});
        vecs.push_back('{1, 1, 16'h003E, 32'h01020304, 4'hF, 0, 32'h0, 0});
        vecs.push_back('{1, 0, 16'h003C, 32'h0,        4'hF, 0, 32'h01020304, 0});
        vecs.push_back('{2, 1, 16'h0010, 32'hA5A5A5A5, 4'h8, 0, 32'h0, 0});
        vecs.push_back('{2, 0, 16'h0010, 32'h0,        4'hF, 0, 32'hA5000000, 0});

        repeat (3) @(negedge clock);
        #1;
        for (int k = 0; k < NINST; k++) begin
            checkOutput($sformatf("reset_pready_i%0d", k), 512'(pready[k]), 512'(0));
            checkOutput($sformatf("reset_prdata_i%0d", k), 512'(prdata[k]), 512'(0));
        end
        @(negedge clock);
        preset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NINST; k++) begin
            checkOutput($sformatf("reset_reg_out_i%0d", k), reg_out[k], 512'(0));
            checkOutput($sformatf("reset_pslverr_i%0d", k), 512'(pslverr[k]), 512'(0));
        end

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                          vecs[i].b2b, rd, er);
            checkOutput($sformatf("vec%0d_err", i), 512'(er), 512'(vecs[i].exp_err));
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d_rdata", i), 512'(rd), 512'(vecs[i].exp_rdata));
        end

        // Back-to-back write then read of register 0 takes exactly 4 edges
        start = cyc;
        applyStimulus(0, 1'b1, 16'h0000, 32'h00000000, 4'hF, 1'b1, rd, er);
        applyStimulus(0, 1'b0, 16'h0000, 32'h0, 4'hF, 1'b1, rd, er);
        checkOutput("b2b_cycles", 512'(last_done_cyc - start), 512'(4));
        checkOutput("b2b_rdata", 512'(rd), 512'(0));
        bus_idle(0);
        @(negedge clock);

        // Access-phase handshake without a setup phase must be ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 16'h0008; pwdata[0] = 32'h55555555; pstrb[0] = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("idle_ignore_pready_c%0d", c), 512'(pready[0]), 512'(0));
            @(negedge clock);
        end
        checkOutput("idle_ignore_reg_out", reg_out[0], model_flat(0));
        bus_idle(0);
        @(negedge clock);

        // Master abort mid-wait on the 2-wait bank
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 16'h000C; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
        @(negedge clock);
        penable[1] = 1'b1;
        #1;
        checkOutput("abort_pready_wait", 512'(pready[1]), 512'(0));
        @(negedge clock);
        bus_idle(1);
        repeat (3) @(negedge clock);
        #1;
        checkOutput("abort_pready_after", 512'(pready[1]), 512'(0));
        checkOutput("abort_no_commit", reg_out[1], model_flat(1));
        checkOutput("abort_prdata_hold", 512'(prdata[1]), 512'(model_prdata[1]));
        @(negedge clock);
        applyStimulus(1, 1'b1, 16'h000C, 32'h0BADCAFE, 4'hF, 1'b0, rd, er);
        applyStimulus(1, 1'b0, 16'h000C, 32'h0, 4'hF, 1'b0, rd, er);
        checkOutput("abort_next_rdata", 512'(rd), 512'(32'h0BADCAFE));

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            int k;
            int idx;
            logic [15:0] a;
            logic [31:0] exp_rd;
            bit wr;
            k = $urandom_range(0, NINST - 1);
            idx = $urandom_range(0, NREGS + 3);
            a = {idx[13:0], 2'($urandom)};
            wr = 1'($urandom);
            exp_rd = (idx >= NREGS) ? 32'h0 : model_mem[k][idx];
            applyStimulus(k, wr, a, $urandom, 4'($urandom), 1'($urandom), rd, er);
            if (!wr) checkOutput($sformatf("rand%0d_rdata", n), 512'(rd), 512'(exp_rd));
        end
        for (int k = 0; k < NINST; k++) bus_idle(k);
        @(negedge clock);

        // Reset asserted while the 3-wait bank is presenting PREADY on a write
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 16'h0014; pwdata[2] = 32'h55AA55AA; pstrb[2] = 4'hF;
        @(negedge clock);
        penable[2] = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_pready_before", 512'(pready[2]), 512'(1));
        preset = 1'b1;
        #1;
        model_reset();
        checkOutput("rst_pready_drop", 512'(pready[2]), 512'(0));
        checkOutput("rst_reg_out", reg_out[2], 512'(0));
        @(negedge clock);
        preset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput($sformatf("rst_idle_pready_c%0d", c), 512'(pready[2]), 512'(0));
            @(negedge clock);
        end
        checkOutput("rst_no_commit", reg_out[2], model_flat(2));
        checkOutput("rst_prdata", 512'(prdata[2]), 512'(0));
        bus_idle(2);
        @(negedge clock);
        applyStimulus(2, 1'b0, 16'h0014, 32'h0, 4'hF, 1'b0, rd, er);
        checkOutput("rst_after_read", 512'(rd), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
